multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Control FSM for the multi-cycle CPU. Sequences a shared ALU, a single unified
//  instruction/data memory port, IR, PC and register file through FETCH/DECODE/EXEC/MEM/WB.
//  Supports R-type, jr, addi, slti, beq, lw, sw, j and jal. Includes a bounded-wait
//  handshake to memory.
//  Sits between the IR opcode/funct fields and the datapath muxes and write enables.
// PARAMETERS
//  TIMEOUT  16  max cycles to wait for mem_ready_i per access; 0 = wait forever
// PORTS
//  clk_i        in   1  clock, rising edge
//  rst_i        in   1  asynchronous reset, active-high
//  instr_op_i   in   6  IR[31:26]
//  funct_i      in   6  IR[5:0]
//  zero_i       in   1  ALU zero flag
//  mem_ready_i  in   1  memory completes access this cycle
//  mem_req_o    out  1  memory access request
//  mem_we_o     out  1  1 = write (sw)
//  IorD_o       out  1  memory address: 0 = PC, 1 = ALUOut
//  IR_write_o   out  1  load IR and MDR from memory read data
//  PC_write_o   out  1  PC load enable
//  PC_src_o     out  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump target, 3 = rs (jr)
//  ALUSrcA_o    out  1  0 = PC, 1 = rs
//  ALUSrcB_o    out  2  0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm << 2
//  ALU_op_o     out  3  000 = add, 001 = sub, 010 = R-type (use funct), 100 = slt
//  RegWrite_o   out  1  register file write enable
//  RegDst_o     out  2  0 = rt, 1 = rd, 2 = $31
//  MemtoReg_o   out  2  0 = ALUOut, 1 = MDR, 2 = PC (+4 already applied)
//  err_o        out  1  1-cycle pulse on illegal opcode or memory timeout
//  state_o      out  3  current state, for debug
// BEHAVIOUR
//  Reset
//   - While rst_i is high: state = FETCH, wait counter = 0, every output = 0.
//   - Asserting rst_i mid-instruction aborts it immediately, with no write strobe.
//  States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, JUMP=6.
//  Outputs are decoded from the state plus the latched op_q/funct_q. Gating by mem_ready_i
//  and zero_i is the only Mealy part. Any output not listed for a state is 0.
//  FETCH
//   - Asserts mem_req_o=1, IorD_o=0.
//   - On the cycle mem_ready_i=1: IR_write_o=1, PC_write_o=1, PC_src_o=0, ALUSrcA_o=0,
//     ALUSrcB_o=1, ALU_op_o=000, then go to DECODE.
//  DECODE (1 cycle)
//   - Latches op_q/funct_q from the inputs. ALUSrcA_o=0, ALUSrcB_o=3, ALU_op_o=000
//     (computes the branch target).
//   - Next state: R-type with funct != 8 -> EXEC; R-type with funct = 8 (jr) -> JUMP;
//     addi(8)/slti(10)/lw(35)/sw(43) -> EXEC; beq(4) -> BRANCH; j(2)/jal(3) -> JUMP.
//   - Any other opcode -> FETCH with err_o pulsed; PC has already advanced.
//  EXEC (1 cycle), ALUSrcA_o=1
//   - R: ALUSrcB_o=0, ALU_op_o=010.
//   - addi/lw/sw: ALUSrcB_o=2, ALU_op_o=000.
//   - slti: ALUSrcB_o=2, ALU_op_o=100.
//   - Next state: lw/sw -> MEM; otherwise -> WB.
//  MEM
//   - mem_req_o=1, IorD_o=1, mem_we_o=(op_q==sw).
//   - On mem_ready_i: lw -> WB (IR_write_o stays 0; MDR loads from its own capture);
//     sw -> FETCH.
//  WB (1 cycle)
//   - RegWrite_o=1.
//   - RegDst_o = 1 for R-type, 0 otherwise.
//   - MemtoReg_o = 1 for lw, 0 otherwise. Then go to FETCH.
//  BRANCH (1 cycle)
//   - ALUSrcA_o=1, ALUSrcB_o=0, ALU_op_o=001, PC_src_o=1, PC_write_o=zero_i.
//     Then go to FETCH.
//  JUMP (1 cycle)
//   - PC_write_o=1; PC_src_o=3 for jr, 2 otherwise.
//   - jal: RegWrite_o=1, RegDst_o=2, MemtoReg_o=2. Then go to FETCH.
//  Memory handshake
//   - mem_req_o, IorD_o and mem_we_o hold stable until mem_ready_i is sampled high.
//   - mem_ready_i is ignored while mem_req_o=0. A ready arriving in the same cycle as the
//     request completes that access: 1-cycle best-case latency.
//  Timeout
//   - A wait counter increments on each cycle with mem_req_o=1 and mem_ready_i=0, and
//     clears on completion or on a state change.
//   - When TIMEOUT != 0 and the counter reaches TIMEOUT-1 while ready is still low:
//     drop the request, pulse err_o, no PC/IR/register write, go to FETCH.
//     A timed-out fetch is retried at the same PC.
//  CPI
//   - With 1-cycle memory: R/addi/slti 4, lw 5, sw 4, beq 3, j/jal/jr 3.
// TESTING
//  1. rst_i pulsed high mid-MEM of an sw -> all outputs 0 within the same cycle; the first
//     post-reset cycle is FETCH with mem_req_o=1.
//  2. addi ($8), ready tied high -> FETCH, DECODE, EXEC(ALUSrcB_o=2), WB(RegWrite_o=1,
//     RegDst_o=0); 4 cycles.
//  3. beq with zero_i=1, then with zero_i=0 -> PC_write_o=1 with PC_src_o=1, then
//     PC_write_o=0; 3 cycles each.
//  4. lw with mem_ready_i delayed 3 cycles in MEM -> mem_req_o/IorD_o stable 4 cycles;
//     WB has MemtoReg_o=1; total 8 cycles.
//  5. TIMEOUT=4, ready never asserted in FETCH -> err_o pulses once after 4 request
//     cycles, no IR_write_o, FETCH restarts.
//  6. Opcode 6'h3F -> err_o pulse in DECODE, next state FETCH, RegWrite_o never asserted.
//  7. jal then jr -> JUMP with RegDst_o=2, MemtoReg_o=2, PC_src_o=2; then PC_src_o=3.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// The controller owns the master side; the datapath and memory see the slave side.
interface multicycle_ctrl_if;
  logic [5:0] instr_op_i;
  logic [5:0] funct_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       mem_req_o;
  logic       mem_we_o;
  logic       IorD_o;
  logic       IR_write_o;
  logic       PC_write_o;
  logic [1:0] PC_src_o;
  logic       ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [2:0] ALU_op_o;
  logic       RegWrite_o;
  logic [1:0] RegDst_o;
  logic [1:0] MemtoReg_o;
  logic       err_o;
  logic [2:0] state_o;

  modport master (
    input  instr_op_i, funct_i, zero_i, mem_ready_i,
    output mem_req_o, mem_we_o, IorD_o, IR_write_o, PC_write_o, PC_src_o, ALUSrcA_o,
           ALUSrcB_o, ALU_op_o, RegWrite_o, RegDst_o, MemtoReg_o, err_o, state_o
  );

  modport slave (
    output instr_op_i, funct_i, zero_i, mem_ready_i,
    input  mem_req_o, mem_we_o, IorD_o, IR_write_o, PC_write_o, PC_src_o, ALUSrcA_o,
           ALUSrcB_o, ALU_op_o, RegWrite_o, RegDst_o, MemtoReg_o, err_o, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB/BRANCH/JUMP sequencing with a
// bounded-wait memory handshake (TIMEOUT = 0 waits forever).
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  multicycle_ctrl_if.master bus
);

  localparam logic [5:0] OpR    = 6'd0;
  localparam logic [5:0] OpJ    = 6'd2;
  localparam logic [5:0] OpJal  = 6'd3;
  localparam logic [5:0] OpBeq  = 6'd4;
  localparam logic [5:0] OpAddi = 6'd8;
  localparam logic [5:0] OpSlti = 6'd10;
  localparam logic [5:0] OpLw   = 6'd35;
  localparam logic [5:0] OpSw   = 6'd43;
  localparam logic [5:0] FnJr   = 6'd8;

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StBranch = 3'd5,
    StJump   = 3'd6
  } state_e;

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_wait;
  logic [5:0]      r_op, r_funct;

  logic w_mem_phase, w_done, w_waiting, w_timeout, w_dec_legal;
  logic w_is_r, w_is_jr, w_is_lw, w_is_sw, w_is_slti, w_is_jal;

  assign w_mem_phase = (r_state == StFetch) || (r_state == StMem);
  assign w_done      = w_mem_phase && bus.mem_ready_i;
  assign w_waiting   = w_mem_phase && !bus.mem_ready_i;
  assign w_timeout   = (TIMEOUT != 0) && w_waiting && (r_wait == CntW'(TIMEOUT - 1));
  assign w_dec_legal = bus.instr_op_i inside {OpR, OpJ, OpJal, OpBeq, OpAddi, OpSlti, OpLw, OpSw};

  assign w_is_r    = (r_op == OpR) && (r_funct != FnJr);
  assign w_is_jr   = (r_op == OpR) && (r_funct == FnJr);
  assign w_is_lw   = (r_op == OpLw);
  assign w_is_sw   = (r_op == OpSw);
  assign w_is_slti = (r_op == OpSlti);
  assign w_is_jal  = (r_op == OpJal);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Wait counter clears whenever the current access completes, times out or isn't waiting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait <= '0;
    end else if (w_waiting && !w_timeout) begin
      r_wait <= r_wait + 1'b1;
    end else begin
      r_wait <= '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op    <= '0;
      r_funct <= '0;
    end else if (r_state == StDecode) begin
      r_op    <= bus.instr_op_i;
      r_funct <= bus.funct_i;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StFetch: begin
        if (w_done) w_state_next = StDecode;
      end
      StDecode: begin
        case (bus.instr_op_i)
          OpR:                         w_state_next = (bus.funct_i == FnJr) ? StJump : StExec;
          OpAddi, OpSlti, OpLw, OpSw:  w_state_next = StExec;
          OpBeq:                       w_state_next = StBranch;
          OpJ, OpJal:                  w_state_next = StJump;
          default:                     w_state_next = StFetch;
        endcase
      end
      StExec:   w_state_next = (w_is_lw || w_is_sw) ? StMem : StWb;
      StMem: begin
        if (w_done)         w_state_next = w_is_lw ? StWb : StFetch;
        else if (w_timeout) w_state_next = StFetch;
      end
      default:  w_state_next = StFetch;
    endcase
  end

  // Reset gates every output low, so an aborted instruction never leaves a write strobe.
  always_comb begin
    bus.mem_req_o  = 1'b0;
    bus.mem_we_o   = 1'b0;
    bus.IorD_o     = 1'b0;
    bus.IR_write_o = 1'b0;
    bus.PC_write_o = 1'b0;
    bus.PC_src_o   = 2'd0;
    bus.ALUSrcA_o  = 1'b0;
    bus.ALUSrcB_o  = 2'd0;
    bus.ALU_op_o   = 3'b000;
    bus.RegWrite_o = 1'b0;
    bus.RegDst_o   = 2'd0;
    bus.MemtoReg_o = 2'd0;
    bus.err_o      = 1'b0;
    if (!rst_i) begin
      unique case (r_state)
        StFetch: begin
          bus.mem_req_o = 1'b1;
          bus.err_o     = w_timeout;
          if (w_done) begin
            bus.IR_write_o = 1'b1;
            bus.PC_write_o = 1'b1;
            bus.ALUSrcB_o  = 2'd1;
          end
        end
        StDecode: begin
          bus.ALUSrcB_o = 2'd3;
          bus.err_o     = !w_dec_legal;
        end
        StExec: begin
          bus.ALUSrcA_o = 1'b1;
          bus.ALUSrcB_o = w_is_r ? 2'd0 : 2'd2;
          bus.ALU_op_o  = w_is_r ? 3'b010 : (w_is_slti ? 3'b100 : 3'b000);
        end
        StMem: begin
          bus.mem_req_o = 1'b1;
          bus.IorD_o    = 1'b1;
          bus.mem_we_o  = w_is_sw;
          bus.err_o     = w_timeout;
        end
        StWb: begin
          bus.RegWrite_o = 1'b1;
          bus.RegDst_o   = w_is_r ? 2'd1 : 2'd0;
          bus.MemtoReg_o = w_is_lw ? 2'd1 : 2'd0;
        end
        StBranch: begin
          bus.ALUSrcA_o  = 1'b1;
          bus.ALU_op_o   = 3'b001;
          bus.PC_src_o   = 2'd1;
          bus.PC_write_o = bus.zero_i;
        end
        StJump: begin
          bus.PC_write_o = 1'b1;
          bus.PC_src_o   = w_is_jr ? 2'd3 : 2'd2;
          if (w_is_jal) begin
            bus.RegWrite_o = 1'b1;
            bus.RegDst_o   = 2'd2;
            bus.MemtoReg_o = 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.state_o = r_state;

endmodule
